// File: rtl/pic_pkg.sv
// Shared types and constants for the PIC-style fetch front end.
package pic_pkg;

    localparam int ADDR_W      = 11;
    localparam int INSTR_W     = 14;
    localparam int STACK_DEPTH = 8;

    typedef logic [ADDR_W-1:0]  pc_t;
    typedef logic [INSTR_W-1:0] instr_t;

    localparam instr_t NOP_INSTR = 14'h0000;

endpackage

// File: rtl/hw_stack.sv
// Circular return-address stack. sp wraps freely; depth saturates and drives
// the sticky overflow/underflow flags. Entries are intentionally not reset.
module hw_stack #(
    parameter int DEPTH = 8,
    parameter int W     = 11,
    parameter int SP_W  = $clog2(DEPTH),
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] top,
    output logic         ovf,
    output logic         unf
);

    logic [W-1:0]     mem [DEPTH];
    logic [SP_W-1:0]  sp_q, sp_d;
    logic [CNT_W-1:0] depth_q, depth_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    // Top of stack is the entry just below sp, wrapping circularly.
    assign top = mem[sp_q - SP_W'(1)];
    assign ovf = ovf_q;
    assign unf = unf_q;

    // Pointer, occupancy and flag update; pop has priority over push.
    always_comb begin
        sp_d    = sp_q;
        depth_d = depth_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        if (pop) begin
            sp_d = sp_q - SP_W'(1);
            if (depth_q == '0) unf_d = 1'b1;
            else               depth_d = depth_q - CNT_W'(1);
        end else if (push) begin
            sp_d = sp_q + SP_W'(1);
            if (depth_q == CNT_W'(DEPTH)) ovf_d = 1'b1;
            else                          depth_d = depth_q + CNT_W'(1);
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q    <= '0;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            sp_q    <= sp_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Entry storage; a full stack simply overwrites the oldest slot.
    always_ff @(posedge clk) begin
        if (push && !pop) mem[sp_q] <= din;
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch front end: program counter, instruction register and
// return stack. Any redirect (pop, load, skip) replaces the in-flight word
// with a NOP bubble.
module pc_fetch_unit
    import pic_pkg::*;
#(
    parameter pc_t RESET_VECTOR = 11'h000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               pc_load,
    input  logic [ADDR_W-1:0]  load_addr,
    input  logic               push,
    input  logic               pop,
    input  logic               skip,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [INSTR_W-1:0] rom_data,
    output logic [INSTR_W-1:0] ir,
    output logic               ir_valid,
    output logic [ADDR_W-1:0]  pc_out,
    output logic               stack_ovf,
    output logic               stack_unf
);

    pc_t    pc_q, pc_d;
    instr_t ir_q, ir_d;
    logic   ir_valid_q, ir_valid_d;
    pc_t    stack_top;
    logic   stk_push, stk_pop;

    // Stall freezes the stack too; pop overrides any simultaneous load/push.
    assign stk_pop  = !stall && pop;
    assign stk_push = !stall && !pop && pc_load && push;

    hw_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (ADDR_W)
    ) u_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (stk_push),
        .pop   (stk_pop),
        .din   (pc_q),
        .top   (stack_top),
        .ovf   (stack_ovf),
        .unf   (stack_unf)
    );

    // Next PC / IR selection: stall > pop > load > skip > sequential fetch.
    always_comb begin
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        if (stall) begin
            pc_d = pc_q;
        end else if (pop) begin
            pc_d       = stack_top;
            ir_d       = NOP_INSTR;
            ir_valid_d = 1'b0;
        end else if (pc_load) begin
            pc_d       = load_addr;
            ir_d       = NOP_INSTR;
            ir_valid_d = 1'b0;
        end else if (skip) begin
            pc_d       = pc_q + pc_t'(1);
            ir_d       = NOP_INSTR;
            ir_valid_d = 1'b0;
        end else begin
            pc_d       = pc_q + pc_t'(1);
            ir_d       = rom_data;
            ir_valid_d = 1'b1;
        end
    end

    // PC and IR registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_VECTOR;
            ir_q       <= NOP_INSTR;
            ir_valid_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
        end
    end

    assign rom_addr = pc_q;
    assign pc_out   = pc_q;
    assign ir       = ir_q;
    assign ir_valid = ir_valid_q;

endmodule
